cmd_issuer: RTL
===============

Name: cmd_issuer

Overview:
- Initiator side of the processor-to-SDRAM-controller command interface.
- Accepts host requests over a valid/ready port and encodes each as a 3-bit cmd plus address.
- Holds the command stable until cmdack, then returns the bus to NOP.
- Optionally generates periodic auto-refresh commands, with arbitration against host requests. Sits between the processor bus logic and the SDRAM controller command decoder.

Parameters:
- padd_size, 24, address width of req_addr/paddr.
- cmd_size, 3, command code width.
- ACK_TIMEOUT, 64, cycles in WAIT_ACK without cmdack before abort (minimum 2).
- RF_W, 16, refresh period counter width.

Ports:
- clk0  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  host request present.
- req_ready  out  1  issuer can accept a request this cycle.
- req_cmd  in  cmd_size  requested command code.
- req_addr  in  padd_size  requested address.
- rf_period  in  RF_W  auto-refresh interval in cycles; 0 disables the timer.
- cmdack  in  1  acknowledge from the SDRAM controller.
- cmd  out  cmd_size  registered command to the controller.
- paddr  out  padd_size  registered address to the controller.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a command is acknowledged.
- timeout_err  out  1  one-cycle pulse on acknowledge timeout.
- rf_pending  out  1  auto-refresh is waiting to be issued.

Behaviour:
- Command encodings:
  - 000 NOP, 001 READA, 010 WRITEA, 011 REFRESH.
  - 100 PRECHARGE, 101 LOAD_MODE, 110 LOAD_TIME, 111 LOAD_RFCNT.
- Reset (synchronous, active-high):
  - state IDLE; cmd=000, paddr=0.
  - busy=0, done=0, timeout_err=0, rf_pending=0.
  - refresh counter=0, timeout counter=0.
  - Reset mid-operation drops any in-flight command with no done or timeout_err pulse; cmd=000 from the next cycle.
- req_ready is combinational: high only when state==IDLE and rf_pending==0. A transfer occurs on req_valid & req_ready at a rising edge.
- IDLE: cmd=000.
  - If rf_pending: load cmd=011, paddr=0, clear rf_pending, go WAIT_ACK.
  - Else on transfer with req_cmd!=000: load cmd/paddr from the request, go WAIT_ACK.
  - Else on transfer with req_cmd==000: pulse done next cycle, stay IDLE, no bus activity.
- WAIT_ACK: cmd/paddr held stable; timeout counter increments each cycle starting from 0.
  - cmdack==1: done=1 for one cycle, cmd=000, go RELEASE.
  - Else counter==ACK_TIMEOUT-1: timeout_err=1 for one cycle, cmd=000, go RELEASE.
  - cmdack wins if both conditions occur in the same cycle.
- RELEASE: cmd=000; stay while cmdack==1; go IDLE on the first cycle cmdack==0. This guarantees at least one NOP cycle between commands, so the controller's LOAD_TIME/LOAD_RFCNT strobes re-arm.
- Latency:
  - Request accepted at edge N: cmd visible after edge N.
  - cmdack sampled high at edge M: done high in cycle M to M+1, cmd=000 after edge M.
  - Minimum back-to-back spacing: 3 cycles.
- Arbitration: a pending refresh beats a simultaneous host request; the host request waits with req_ready low and is not lost while req_valid is held.

Optional Feature:
- Macro: AUTO_REFRESH_EN.
- Defined:
  - RF_W down-counter; on a cycle where counter==0 and rf_period!=0, reload rf_period and set rf_pending; otherwise decrement if nonzero.
  - Expiry while rf_pending is already set is absorbed, not counted.
  - rf_period==0: counter idles at 0 and no refresh is generated.
- Undefined: no counter is built; rf_pending is tied 0 and rf_period is ignored. REFRESH is issued only via a host req_cmd=011.

Decomposition:
- Shared package: cmd encoding constants (CMD_NOP … CMD_LOAD_RFCNT), the FSM state typedef (IDLE, WAIT_ACK, RELEASE), and default widths. These constants are shared with the command decoder.
- One sub-module, refresh_timer: the RF_W counter plus pending flag with set/clear ports, instantiated only under AUTO_REFRESH_EN.

Test Plan:
- READA: req_cmd=001, req_addr=24'h12_3456, cmdack high 3 cycles after issue, for 1 cycle -> cmd=001 and paddr=24'h12_3456 stable until ack; done single pulse; cmd=000 next cycle; req_ready returns 1 two cycles later.
- Timeout: ACK_TIMEOUT=16, WRITEA, cmdack never asserted -> timeout_err pulse exactly 16 cycles after cmd=010 appears; done never asserts; cmd=000 after.
- Arbitration (AUTO_REFRESH_EN): rf_period=10, host LOAD_MODE held valid as the timer expires -> cmd=011 with paddr=0 issued first, then cmd=101 after the ack/release sequence; rf_pending clears on refresh issue.
- Sticky ack: cmdack held high 5 cycles -> done pulses once; state stays RELEASE and req_ready stays 0 until cmdack falls, then IDLE.
- Reset mid-operation: sync reset asserted during WAIT_ACK -> after next edge cmd=000, paddr=0, busy=0; no done or timeout_err pulse.
- Disabled timer: rf_period=0 for 1000 cycles -> rf_pending never asserts and cmd never equals 011.

Source files
------------

// File: rtl/cmd_issuer_pkg.sv
// Shared definitions for the SDRAM command interface: command codes, issuer FSM states, default widths.
// These command codes are also used by the controller-side command decoder.
package cmd_issuer_pkg;

   localparam int PADD_SIZE_DEF   = 24;
   localparam int CMD_SIZE_DEF    = 3;
   localparam int ACK_TIMEOUT_DEF = 64;
   localparam int RF_W_DEF        = 16;

   localparam logic [2:0] CMD_NOP        = 3'b000;
   localparam logic [2:0] CMD_READA      = 3'b001;
   localparam logic [2:0] CMD_WRITEA     = 3'b010;
   localparam logic [2:0] CMD_REFRESH    = 3'b011;
   localparam logic [2:0] CMD_PRECHARGE  = 3'b100;
   localparam logic [2:0] CMD_LOAD_MODE  = 3'b101;
   localparam logic [2:0] CMD_LOAD_TIME  = 3'b110;
   localparam logic [2:0] CMD_LOAD_RFCNT = 3'b111;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      WAIT_ACK = 2'b01,
      RELEASE  = 2'b10
   } state_t;

   function automatic logic is_nop(input logic [2:0] code);
      return (code == CMD_NOP);
   endfunction

endpackage

// File: rtl/cmd_issuer_refresh_timer.sv
// Auto-refresh interval down-counter with a sticky pending flag.
// Only built when AUTO_REFRESH_EN is defined; otherwise this file is empty.
`ifdef AUTO_REFRESH_EN
module cmd_issuer_refresh_timer
   import cmd_issuer_pkg::*;
#(
   parameter int RF_W = RF_W_DEF
) (
   input  logic            clk0,
   input  logic            reset,
   input  logic [RF_W-1:0] rf_period,
   input  logic            clear,
   output logic            pending
);

   logic [RF_W-1:0] cnt_r;
   logic            pending_r;
   logic            expire_s;

   // Expiry: counter reached zero while a non-zero period is programmed.
   always_comb begin
      expire_s = 1'b0;
      if ((cnt_r == '0) && (rf_period != '0)) begin
         expire_s = 1'b1;
      end else begin
         expire_s = 1'b0;
      end
   end

   // Counter reload/decrement and pending flag; clear only occurs while pending, so a
   // coincident expiry is absorbed rather than re-arming the flag.
   always_ff @(posedge clk0) begin
      if (reset) begin
         cnt_r     <= '0;
         pending_r <= 1'b0;
      end else begin
         if (expire_s) begin
            cnt_r <= rf_period;
         end else if (cnt_r != '0) begin
            cnt_r <= cnt_r - RF_W'(1);
         end else begin
            cnt_r <= cnt_r;
         end
         if (clear) begin
            pending_r <= 1'b0;
         end else if (expire_s) begin
            pending_r <= 1'b1;
         end else begin
            pending_r <= pending_r;
         end
      end
   end

   assign pending = pending_r;

endmodule
`endif

// File: rtl/cmd_issuer.sv
// Initiator side of the processor-to-SDRAM-controller command interface.
// Optional periodic auto-refresh is enabled by defining AUTO_REFRESH_EN.
module cmd_issuer
   import cmd_issuer_pkg::*;
#(
   parameter int padd_size   = PADD_SIZE_DEF,
   parameter int cmd_size    = CMD_SIZE_DEF,
   parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
   parameter int RF_W        = RF_W_DEF
) (
   input  logic                 clk0,
   input  logic                 reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [cmd_size-1:0]  req_cmd,
   input  logic [padd_size-1:0] req_addr,
   input  logic [RF_W-1:0]      rf_period,
   input  logic                 cmdack,
   output logic [cmd_size-1:0]  cmd,
   output logic [padd_size-1:0] paddr,
   output logic                 busy,
   output logic                 done,
   output logic                 timeout_err,
   output logic                 rf_pending
);

   localparam int TO_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

   state_t               state_r;
   logic [cmd_size-1:0]  cmd_r;
   logic [padd_size-1:0] paddr_r;
   logic                 busy_r;
   logic                 done_r;
   logic                 timeout_err_r;
   logic [TO_W-1:0]      to_cnt_r;
   logic                 rf_pending_s;
   logic                 ready_s;

`ifdef AUTO_REFRESH_EN
   logic rf_clear_s;

   // A pending refresh is consumed the cycle the FSM launches it from IDLE.
   always_comb begin
      rf_clear_s = 1'b0;
      if ((state_r == IDLE) && rf_pending_s) begin
         rf_clear_s = 1'b1;
      end else begin
         rf_clear_s = 1'b0;
      end
   end

   cmd_issuer_refresh_timer #(
      .RF_W (RF_W)
   ) refresh_timer (
      .clk0      (clk0),
      .reset     (reset),
      .rf_period (rf_period),
      .clear     (rf_clear_s),
      .pending   (rf_pending_s)
   );
`else
   logic unused_rf_period_s;
   assign unused_rf_period_s = |rf_period;
   assign rf_pending_s       = 1'b0;
`endif

   // Host may transfer only in IDLE with no refresh waiting; refresh wins arbitration.
   always_comb begin
      ready_s = 1'b0;
      if ((state_r == IDLE) && !rf_pending_s) begin
         ready_s = 1'b1;
      end else begin
         ready_s = 1'b0;
      end
   end

   // Command FSM: issue, hold until ack or timeout, then force at least one NOP.
   always_ff @(posedge clk0) begin
      if (reset) begin
         state_r       <= IDLE;
         cmd_r         <= cmd_size'(CMD_NOP);
         paddr_r       <= '0;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
         timeout_err_r <= 1'b0;
         to_cnt_r      <= '0;
      end else begin
         done_r        <= 1'b0;
         timeout_err_r <= 1'b0;
         case (state_r)
            IDLE: begin
               cmd_r    <= cmd_size'(CMD_NOP);
               to_cnt_r <= '0;
               if (rf_pending_s) begin
                  cmd_r   <= cmd_size'(CMD_REFRESH);
                  paddr_r <= '0;
                  busy_r  <= 1'b1;
                  state_r <= WAIT_ACK;
               end else if (req_valid && !is_nop(3'(req_cmd))) begin
                  cmd_r   <= req_cmd;
                  paddr_r <= req_addr;
                  busy_r  <= 1'b1;
                  state_r <= WAIT_ACK;
               end else if (req_valid) begin
                  done_r  <= 1'b1;
               end else begin
                  state_r <= IDLE;
               end
            end
            WAIT_ACK: begin
               if (cmdack) begin
                  done_r  <= 1'b1;
                  cmd_r   <= cmd_size'(CMD_NOP);
                  state_r <= RELEASE;
               end else if (to_cnt_r == TO_W'(ACK_TIMEOUT - 1)) begin
                  timeout_err_r <= 1'b1;
                  cmd_r         <= cmd_size'(CMD_NOP);
                  state_r       <= RELEASE;
               end else begin
                  to_cnt_r <= to_cnt_r + TO_W'(1);
               end
            end
            RELEASE: begin
               cmd_r <= cmd_size'(CMD_NOP);
               if (!cmdack) begin
                  busy_r  <= 1'b0;
                  state_r <= IDLE;
               end else begin
                  state_r <= RELEASE;
               end
            end
            default: begin
               cmd_r   <= cmd_size'(CMD_NOP);
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign req_ready   = ready_s;
   assign cmd         = cmd_r;
   assign paddr       = paddr_r;
   assign busy        = busy_r;
   assign done        = done_r;
   assign timeout_err = timeout_err_r;
   assign rf_pending  = rf_pending_s;

endmodule
